seq_frame_ctrl: RTL and testbench

Frame-level controller for serial pattern detection. Accepts parallel words over a valid/ready handshake and serialises them MSB-first into a programmable pattern matcher. It counts matches over a frame of cfg_len words and reports completion. It sits between a word-oriented producer and the serial-detection datapath, and it sequences load, shift and report phases.

---
 rtl/seq_frame_ctrl.sv | 113 +++++++++++
 tb/tb_seq_frame_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_ctrl.sv
// Frame controller: takes words over valid/ready, shifts them out MSB-first
// and counts serial pattern matches across a frame of cfg_len words.
module seq_frame_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t              state;
  logic [WORD_W-1:0]   sreg;
  logic [PAT_W-1:0]    pat;
  logic [PAT_W-1:0]    hist;
  logic                ovl;
  logic [LEN_W-1:0]    words_left;
  logic [BIT_W-1:0]    bit_cnt;
  logic [FILL_W-1:0]   fill;

  logic [PAT_W:0]      hist_ext;
  logic [PAT_W-1:0]    hist_nxt;
  logic [FILL_W-1:0]   fill_nxt;
  logic                hit;
  logic                last_bit;

  // History/fill as they will be after the bit currently on ser_bit.
  always_comb begin
    hist_ext = {hist, sreg[WORD_W-1]};
    hist_nxt = hist_ext[PAT_W-1:0];
    fill_nxt = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
    hit      = (hist_nxt == pat) && (fill_nxt == FILL_W'(PAT_W));
    last_bit = (bit_cnt == BIT_W'(WORD_W - 1));
  end

  assign word_ready = (state == LOAD);
  assign ser_valid  = (state == SHIFT);
  assign ser_bit    = ser_valid & sreg[WORD_W-1];
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sreg        <= '0;
      pat         <= '0;
      hist        <= '0;
      ovl         <= 1'b0;
      words_left  <= '0;
      bit_cnt     <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= 1'b0;
      if (abort) begin
        // Pending match and done are dropped; match_count is kept.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            pat         <= cfg_pattern;
            ovl         <= cfg_overlap;
            words_left  <= cfg_len;
            match_count <= '0;
            hist        <= '0;
            fill        <= '0;
            bit_cnt     <= '0;
            state       <= (cfg_len != '0) ? LOAD : DONE;
          end
          LOAD: if (word_valid) begin
            sreg       <= word_in;
            words_left <= words_left - LEN_W'(1);
            bit_cnt    <= '0;
            state      <= SHIFT;
          end
          SHIFT: begin
            sreg    <= sreg << 1;
            hist    <= hist_nxt;
            fill    <= (hit && !ovl) ? '0 : fill_nxt;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (hit) begin
              match <= 1'b1;
              if (match_count != '1) match_count <= match_count + CNT_W'(1);
            end
            if (last_bit) state <= (words_left != '0) ? LOAD : DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seq_frame_ctrl.sv
// Bench for seq_frame_ctrl: table of frames checked against a serial-bit and
// match-position scoreboard, plus abort / mid-frame reset sequences.
module tb_seq_frame_ctrl;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_len = '0, word_in = '0;
  logic       word_valid = 1'b0;

  logic       word_ready, ser_bit, ser_valid, match, busy, done;
  logic [7:0] match_count;
  logic       s_word_ready, s_ser_bit, s_ser_valid, s_match, s_busy, s_done;
  logic [1:0] s_match_count;

  seq_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_len(cfg_len),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .match(match),
    .match_count(match_count), .busy(busy), .done(done));

  seq_frame_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_len(cfg_len),
    .word_in(word_in), .word_valid(word_valid), .word_ready(s_word_ready),
    .ser_bit(s_ser_bit), .ser_valid(s_ser_valid), .match(s_match),
    .match_count(s_match_count), .busy(s_busy), .done(s_done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] pat;
    logic       ovl;
    int         len;
    logic [7:0] w0;
    logic [7:0] w1;
    int         bp;
    int         exp_cnt;
    int         exp_sat;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0, errors = 0;
  bit   exp_bit[$];
  int   exp_match[$];
  bit   mon_en = 1'b0;
  int   bits_seen = 0, n_pulse = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every serial bit and every match pulse is popped.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (!busy) begin bits_seen = 0; n_pulse = 0; end
      if (match) begin
        n_pulse++;
        if (exp_match.size() == 0) chk("match_unexpected", int'(match), 0);
        else chk("match_pos", bits_seen, exp_match.pop_front());
      end
      if (ser_valid) begin
        if (exp_bit.size() == 0) chk("ser_unexpected", int'(ser_valid), 0);
        else chk("ser_bit", int'(ser_bit), int'(exp_bit.pop_front()));
        bits_seen++;
      end
    end
  end

  task automatic run_frame(input vec_t v, input string tag);
    int s, m_hist, m_fill, nbit;
    bit got;
    logic [7:0] w;
    exp_bit.delete(); exp_match.delete();
    m_hist = 0; m_fill = 0; nbit = 0;
    @(posedge clk); #1;
    cfg_pattern = v.pat; cfg_overlap = v.ovl; cfg_len = 8'(v.len); start = 1'b1;
    @(posedge clk); #1;
    s = cyc; start = 1'b0;
    // Config is latched at start; scrambling it afterwards must have no effect.
    cfg_pattern = ~v.pat; cfg_overlap = ~v.ovl; cfg_len = 8'd3;
    for (int j = 0; j < v.len; j++) begin
      w = (j == 0) ? v.w0 : v.w1;
      if (j == 0) repeat (v.bp) begin
        @(negedge clk);
        chk({tag, "_bp_hold"}, int'({word_ready, ser_valid, busy}), 5);
        @(posedge clk); #1;
      end
      word_in = w; word_valid = 1'b1;
      for (int b = 7; b >= 0; b--) begin
        exp_bit.push_back(w[b]);
        nbit++;
        m_hist = ((m_hist << 1) | int'(w[b])) & 15;
        if (m_fill < 4) m_fill++;
        if (m_fill == 4 && m_hist == int'(v.pat)) begin
          exp_match.push_back(nbit);
          if (!v.ovl) m_fill = 0;
        end
      end
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        if (word_ready) got = 1'b1;
      end
      if (!got) chk({tag, "_accept_timeout"}, int'(word_ready), 1);
      @(posedge clk); #1;
      word_valid = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) chk({tag, "_done_timeout"}, int'(done), 1);
    else begin
      chk({tag, "_done_lat"}, cyc - s, v.len * 9 + v.bp);
      chk({tag, "_count"}, int'(match_count), v.exp_cnt);
      chk({tag, "_count_sat"}, int'(s_match_count), v.exp_sat);
    end
    @(posedge clk); #1;
    chk({tag, "_pulses"}, n_pulse, v.exp_pulses);
    chk({tag, "_sb_left"}, exp_bit.size() + exp_match.size(), 0);
  endtask

  // Start a one-word frame and stop in the cycle carrying serial bit n.
  task automatic start_to_bit(input logic [3:0] p, input logic [7:0] w, input int n);
    int cnt;
    @(posedge clk); #1;
    cfg_pattern = p; cfg_overlap = 1'b1; cfg_len = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; word_in = w; word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && cnt < n; k++) begin
      @(negedge clk);
      if (ser_valid) cnt++;
    end
    if (cnt != n) chk("bit_reach_timeout", cnt, n);
  endtask

  initial begin
    vecs[0] = '{4'b1011, 1'b1, 1, 8'hBB, 8'h00, 0, 2, 2, 2};
    vecs[1] = '{4'b1010, 1'b1, 1, 8'hAA, 8'h00, 0, 3, 3, 3};
    vecs[2] = '{4'b1010, 1'b0, 1, 8'hAA, 8'h00, 0, 2, 2, 2};
    vecs[3] = '{4'b1011, 1'b1, 2, 8'h01, 8'h60, 0, 1, 1, 1};
    vecs[4] = '{4'b1011, 1'b1, 1, 8'hBB, 8'h00, 5, 2, 2, 2};
    vecs[5] = '{4'b1010, 1'b1, 2, 8'hAA, 8'hAA, 0, 7, 3, 7};
    vecs[6] = '{4'b1011, 1'b1, 0, 8'h00, 8'h00, 0, 0, 0, 0};
    vecs[7] = '{4'b1111, 1'b0, 2, 8'hFF, 8'hF0, 0, 3, 3, 3};

    repeat (3) @(negedge clk);
    chk("reset_outs", int'({word_ready, ser_bit, ser_valid, match, match_count, busy, done}), 0);
    chk("reset_outs_sat", int'({s_word_ready, s_ser_bit, s_ser_valid, s_match, s_match_count, s_busy, s_done}), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    mon_en = 1'b1;
    for (int i = 0; i < 8; i++)
      if (i != 6) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Abort in the bit-6 cycle: the match completing on that edge is dropped.
    mon_en = 1'b0;
    start_to_bit(4'b1010, 8'hAA, 6);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", int'({busy, ser_valid, match, done}), 0);
    chk("abort_count", int'(match_count), 1);
    chk("abort_count_sat", int'(s_match_count), 1);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end

    // start and abort together in IDLE: abort wins, count untouched.
    @(posedge clk); #1;
    cfg_len = 8'd1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", int'(busy), 0);
    chk("start_abort_count", int'(match_count), 1);

    // Asynchronous reset in the middle of bit 3.
    start_to_bit(4'b1011, 8'hBB, 3);
    #1 rst = 1'b0;
    #1;
    chk("midrst_outs", int'({word_ready, ser_bit, ser_valid, match, busy, done}), 0);
    chk("midrst_count", int'(match_count), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    exp_bit.delete(); exp_match.delete();
    mon_en = 1'b1;
    run_frame(vecs[6], "len0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
